// File: rtl/dsp_rx_if.sv
// Video input / capture output bundle for dsp_rx. The slave side is the receiver;
// the master side is whatever drives video in and consumes captured pixels.
interface dsp_rx_if;
    logic        DSP_HSYNC_X;
    logic        DSP_VSYNC_X;
    logic        DSP_DE;
    logic [7:0]  DSP_R;
    logic [7:0]  DSP_G;
    logic [7:0]  DSP_B;
    logic        PIX_VALID;
    logic [10:0] PIX_X;
    logic [10:0] PIX_Y;
    logic [23:0] PIX_DATA;
    logic        FRAME_START;
    logic [10:0] HACT;
    logic [10:0] VACT;
    logic        LOCKED;
    logic        LOCK_LOST;
    logic [31:0] FRAME_SUM;

    modport master (
        output DSP_HSYNC_X, DSP_VSYNC_X, DSP_DE, DSP_R, DSP_G, DSP_B,
        input  PIX_VALID, PIX_X, PIX_Y, PIX_DATA, FRAME_START,
        input  HACT, VACT, LOCKED, LOCK_LOST, FRAME_SUM
    );

    modport slave (
        input  DSP_HSYNC_X, DSP_VSYNC_X, DSP_DE, DSP_R, DSP_G, DSP_B,
        output PIX_VALID, PIX_X, PIX_Y, PIX_DATA, FRAME_START,
        output HACT, VACT, LOCKED, LOCK_LOST, FRAME_SUM
    );
endinterface

// File: rtl/dsp_rx.sv
// dsp_rx: registers parallel RGB video, measures active width/height, tracks timing lock
// and tags captured pixels with coordinates. Define DSP_RX_CHECKSUM_EN for FRAME_SUM.
module dsp_rx #(
    parameter int LOCK_FRAMES = 2
) (
    input  logic    DCLK,
    input  logic    ARESETN,
    dsp_rx_if.slave bus
);
    typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCK = 2'd2} state_t;

    localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);
    localparam logic [11:0] HS_LIMIT = 12'hFFF;

    function automatic logic [10:0] sat11(input logic [11:0] v);
        return v[11] ? 11'h7FF : v[10:0];
    endfunction

    // Counts stop at 2048 so "exceeds 2047" stays visible in bit 11.
    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return v[11] ? v : v + 12'd1;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    logic        hs_p0, vs_p0, vld_p0;
    logic [23:0] rgb_p0;
    logic        vs_p1, vld_p1;
    logic        pix_vld_p1;
    logic [10:0] pix_x_p1, pix_y_p1;
    logic [23:0] pix_data_p1;
    logic [11:0] w_cnt, line_cnt, first_w, hs_cnt;
    logic        first_set, bad;
    state_t      state_q, state_d;
    logic [3:0]  match_q, match_d;
    logic [10:0] hact_q, hact_d, vact_q, vact_d;
    logic        frame_start_q, lock_lost_q, inc;
    logic        bnd, start, run_end, hs_timeout, end_bad, frame_ok;
    logic [11:0] fw;

    // stage p0: input registers
    always_ff @(posedge DCLK or negedge ARESETN) begin
        if (!ARESETN) begin
            hs_p0  <= 1'b0;
            vs_p0  <= 1'b0;
            vld_p0 <= 1'b0;
            rgb_p0 <= '0;
        end else begin
            hs_p0  <= bus.DSP_HSYNC_X;
            vs_p0  <= bus.DSP_VSYNC_X;
            vld_p0 <= bus.DSP_DE;
            rgb_p0 <= {bus.DSP_R, bus.DSP_G, bus.DSP_B};
        end
    end

    assign bnd        = vs_p1 & ~vs_p0;
    assign start      = vld_p0 & ~vld_p1;
    assign run_end    = vld_p1 & ~vld_p0;
    assign hs_timeout = hs_p0 & (hs_cnt == HS_LIMIT);

    // A line closing on the boundary cycle has not been folded into first_w/bad yet.
    assign end_bad  = run_end & ((first_set & (w_cnt != first_w)) | w_cnt[11]);
    assign fw       = first_set ? first_w : (run_end ? w_cnt : 12'd0);
    assign frame_ok = ~bad & ~end_bad & ~vld_p0 & (fw != 12'd0) &
                      (line_cnt != 12'd0) & ~line_cnt[11];

    // stage p1: edge history, coordinates, frame measurement
    always_ff @(posedge DCLK or negedge ARESETN) begin
        if (!ARESETN) begin
            vs_p1       <= 1'b0;
            vld_p1      <= 1'b0;
            pix_vld_p1  <= 1'b0;
            pix_x_p1    <= '0;
            pix_y_p1    <= '0;
            pix_data_p1 <= '0;
            w_cnt       <= '0;
            line_cnt    <= '0;
            first_w     <= '0;
            first_set   <= 1'b0;
            bad         <= 1'b0;
            hs_cnt      <= '0;
        end else begin
            vs_p1      <= vs_p0;
            vld_p1     <= vld_p0;
            pix_vld_p1 <= vld_p0 & (state_q != SEARCH);
            if (vld_p0) begin
                pix_data_p1 <= rgb_p0;
                pix_x_p1    <= start ? 11'd0 : sat11(w_cnt);
                w_cnt       <= start ? 12'd1 : sat_inc12(w_cnt);
                if (start)
                    pix_y_p1 <= bnd ? 11'd0 : sat11(line_cnt);
            end
            if (bnd)
                line_cnt <= start ? 12'd1 : 12'd0;
            else if (start)
                line_cnt <= sat_inc12(line_cnt);
            if (bnd) begin
                first_w   <= '0;
                first_set <= 1'b0;
                bad       <= 1'b0;
            end else if (run_end) begin
                if (!first_set) begin
                    first_w   <= w_cnt;
                    first_set <= 1'b1;
                end else if (w_cnt != first_w) begin
                    bad <= 1'b1;
                end
                if (w_cnt[11])
                    bad <= 1'b1;
            end
            if (!hs_p0)
                hs_cnt <= '0;
            else if (hs_cnt != HS_LIMIT)
                hs_cnt <= hs_cnt + 12'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        hact_d  = hact_q;
        vact_d  = vact_q;
        inc     = 1'b0;
        if (hs_timeout) begin
            state_d = SEARCH;
        end else if (bnd) begin
            if (state_q == SEARCH) begin
                state_d = MEASURE;
                match_d = '0;
            end else begin
                if (frame_ok && fw[10:0] == hact_q && line_cnt[10:0] == vact_q) begin
                    match_d = sat_inc4(match_q);
                    inc     = 1'b1;
                end else if (frame_ok) begin
                    hact_d  = fw[10:0];
                    vact_d  = line_cnt[10:0];
                    match_d = 4'd1;
                end else begin
                    match_d = '0;
                end
                if (state_q == LOCK && !inc)
                    state_d = MEASURE;
                else if (match_d >= LOCK_N)
                    state_d = LOCK;
                else
                    state_d = MEASURE;
            end
        end
    end

    // stage p1: lock state and measured timing, aligned with FRAME_START
    always_ff @(posedge DCLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q       <= SEARCH;
            match_q       <= '0;
            hact_q        <= '0;
            vact_q        <= '0;
            frame_start_q <= 1'b0;
            lock_lost_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            match_q       <= match_d;
            hact_q        <= hact_d;
            vact_q        <= vact_d;
            frame_start_q <= bnd;
            lock_lost_q   <= (state_q == LOCK) && (state_d != LOCK);
        end
    end

`ifdef DSP_RX_CHECKSUM_EN
    logic [31:0] acc_q, acc_nx, sum_q;

    assign acc_nx = acc_q + (pix_vld_p1 ? {8'h00, pix_data_p1} : 32'd0);

    // stage p2: checksum accumulation over captured pixels
    always_ff @(posedge DCLK or negedge ARESETN) begin
        if (!ARESETN) begin
            acc_q <= '0;
            sum_q <= '0;
        end else if (bnd) begin
            sum_q <= acc_nx;
            acc_q <= '0;
        end else begin
            acc_q <= acc_nx;
        end
    end

    assign bus.FRAME_SUM = sum_q;
`else
    assign bus.FRAME_SUM = '0;
`endif

    assign bus.PIX_VALID   = pix_vld_p1;
    assign bus.PIX_X       = pix_x_p1;
    assign bus.PIX_Y       = pix_y_p1;
    assign bus.PIX_DATA    = pix_data_p1;
    assign bus.FRAME_START = frame_start_q;
    assign bus.HACT        = hact_q;
    assign bus.VACT        = vact_q;
    assign bus.LOCKED      = (state_q == LOCK);
    assign bus.LOCK_LOST   = lock_lost_q;
endmodule

// File: tb/tb_dsp_rx.sv
// Bench for dsp_rx: table of scaled-down frames with per-boundary expectations, pixel
// scoreboard, plus HSYNC-loss and mid-line asynchronous reset sequences.
module tb_dsp_rx;
    localparam int LF = 2;

    typedef struct {
        int w; int h; int short_l; bit cpx;
        int hact; int vact; bit locked; bit lost;
    } frame_vec_t;

    typedef struct {
        int hact; int vact; bit locked; bit lost; logic [31:0] sum;
    } status_t;

    logic DCLK = 1'b0;
    logic ARESETN;
    always #5 DCLK = ~DCLK;

    dsp_rx_if bus();
    dsp_rx #(.LOCK_FRAMES(LF)) dut (.DCLK(DCLK), .ARESETN(ARESETN), .bus(bus));

    status_t     st_q[$];
    logic [45:0] px_q[$];
    status_t     exp_st;
    logic [45:0] exp_px;
    frame_vec_t  tbl[13];
    frame_vec_t  fv;
    int          checks = 0;
    int          errors = 0;
    int          lost_extra = 0;
    int          fidx = 0;
    bit          in_search = 1'b1;
    logic [31:0] fsum = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge DCLK) begin
        #1;
        if (ARESETN === 1'b1) begin
            if (bus.PIX_VALID === 1'b1) begin
                if (px_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: x=%0d y=%0d data=%0h none expected",
                             bus.PIX_X, bus.PIX_Y, bus.PIX_DATA);
                end else begin
                    exp_px = px_q.pop_front();
                    check("pixel_xy_data", {bus.PIX_X, bus.PIX_Y, bus.PIX_DATA}, exp_px);
                end
            end
            if (bus.FRAME_START === 1'b1) begin
                if (st_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_start: got 1 expected 0");
                end else begin
                    exp_st = st_q.pop_front();
                    check("hact", bus.HACT, exp_st.hact);
                    check("vact", bus.VACT, exp_st.vact);
                    check("locked", bus.LOCKED, exp_st.locked);
                    check("lock_lost", bus.LOCK_LOST, exp_st.lost);
`ifdef DSP_RX_CHECKSUM_EN
                    check("frame_sum", bus.FRAME_SUM, exp_st.sum);
`else
                    check("frame_sum", bus.FRAME_SUM, 0);
`endif
                end
            end else if (bus.LOCK_LOST === 1'b1) begin
                lost_extra++;
            end
        end
    end

    task automatic drive_cycle(input logic hs, input logic vs, input logic de, input logic [23:0] d);
        @(negedge DCLK);
        bus.DSP_HSYNC_X = hs;
        bus.DSP_VSYNC_X = vs;
        bus.DSP_DE      = de;
        {bus.DSP_R, bus.DSP_G, bus.DSP_B} = d;
    endtask

    // Line layout: 4 cycles HSYNC low, 4 back porch, de_len active, rest front porch.
    task automatic drive_line(input int de_len, input int tot, input logic vs, input int y,
                              input bit cpx, input int stop_at);
        logic        de_i;
        logic [23:0] d;
        for (int c = 0; c < tot; c++) begin
            if (c == stop_at) return;
            de_i = (c >= 8) && (c < 8 + de_len);
            d    = cpx ? 24'h010203 : {8'(c - 8), 8'(y), 8'(fidx)};
            drive_cycle(c >= 4, vs, de_i, de_i ? d : 24'h0);
            if (de_i && !in_search) begin
                px_q.push_back({11'(c - 8), 11'(y), d});
                fsum += {8'h00, d};
            end
        end
    endtask

    // The leading VSYNC fall closes the previous frame; its expectations are queued here.
    task automatic drive_frame(input frame_vec_t v, input int cut_line);
        int      tot;
        status_t s;
        tot      = v.w + 12;
        s.hact   = v.hact;
        s.vact   = v.vact;
        s.locked = v.locked;
        s.lost   = v.lost;
        s.sum    = fsum;
        st_q.push_back(s);
        fsum      = '0;
        in_search = 1'b0;
        fidx++;
        repeat (2) drive_line(0, tot, 1'b0, 0, 1'b0, -1);
        repeat (2) drive_line(0, tot, 1'b1, 0, 1'b0, -1);
        for (int y = 0; y < v.h; y++) begin
            if (y == cut_line) begin
                drive_line(v.w, tot, 1'b1, y, v.cpx, 8 + v.w / 2);
                return;
            end
            drive_line((y == v.short_l) ? v.w - 1 : v.w, tot, 1'b1, y, v.cpx, -1);
        end
        drive_line(0, tot, 1'b1, 0, 1'b0, -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        //          w   h  short cpx hact vact lck lost
        tbl[0]  = '{16, 6, -1, 1'b0,  0, 0, 1'b0, 1'b0};
        tbl[1]  = '{16, 6, -1, 1'b0, 16, 6, 1'b0, 1'b0};
        tbl[2]  = '{16, 6, -1, 1'b0, 16, 6, 1'b1, 1'b0};
        tbl[3]  = '{16, 6,  2, 1'b0, 16, 6, 1'b1, 1'b0};
        tbl[4]  = '{16, 6, -1, 1'b0, 16, 6, 1'b0, 1'b1};
        tbl[5]  = '{16, 6, -1, 1'b0, 16, 6, 1'b0, 1'b0};
        tbl[6]  = '{20, 8, -1, 1'b0, 16, 6, 1'b1, 1'b0};
        tbl[7]  = '{20, 8, -1, 1'b0, 20, 8, 1'b0, 1'b1};
        tbl[8]  = '{20, 0, -1, 1'b0, 20, 8, 1'b1, 1'b0};
        tbl[9]  = '{20, 8, -1, 1'b1, 20, 8, 1'b0, 1'b1};
        tbl[10] = '{20, 8, -1, 1'b0, 20, 8, 1'b0, 1'b0};
        tbl[11] = '{20, 8, -1, 1'b0, 20, 8, 1'b1, 1'b0};
        tbl[12] = '{20, 0, -1, 1'b0, 20, 8, 1'b1, 1'b0};

        ARESETN         = 1'b0;
        bus.DSP_HSYNC_X = 1'b1;
        bus.DSP_VSYNC_X = 1'b1;
        bus.DSP_DE      = 1'b0;
        {bus.DSP_R, bus.DSP_G, bus.DSP_B} = 24'h0;
        repeat (3) @(posedge DCLK);
        #1;
        check("reset_init_outputs",
              {bus.PIX_VALID, bus.PIX_X, bus.PIX_Y, bus.PIX_DATA, bus.FRAME_START, bus.HACT,
               bus.VACT, bus.LOCKED, bus.LOCK_LOST, bus.FRAME_SUM}, 0);
        @(negedge DCLK);
        ARESETN = 1'b1;
        repeat (5) drive_cycle(1'b1, 1'b1, 1'b0, 24'h0);

        for (int i = 0; i < 13; i++)
            drive_frame(tbl[i], -1);

        // HSYNC disappears while locked
        check("pre_watchdog_locked", bus.LOCKED, 1);
        check("pre_watchdog_lost_pulses", lost_extra, 0);
        repeat (4300) drive_cycle(1'b1, 1'b1, 1'b0, 24'h0);
        in_search = 1'b1;
        fsum      = '0;
        check("watchdog_locked", bus.LOCKED, 0);
        check("watchdog_lost_pulses", lost_extra, 1);
        check("watchdog_status_drained", st_q.size(), 0);

        // Relock, then asynchronous reset in the middle of an active line
        fv = '{16, 6, -1, 1'b0, 20, 8, 1'b0, 1'b0};
        drive_frame(fv, -1);
        fv = '{16, 6, -1, 1'b0, 16, 6, 1'b0, 1'b0};
        drive_frame(fv, -1);
        fv = '{16, 6, -1, 1'b0, 16, 6, 1'b1, 1'b0};
        drive_frame(fv, 3);
        check("pre_reset_locked", bus.LOCKED, 1);
        check("pre_reset_de_high", bus.DSP_DE, 1);
        #2;
        ARESETN = 1'b0;
        #1;
        check("reset_async_outputs",
              {bus.PIX_VALID, bus.PIX_X, bus.PIX_Y, bus.PIX_DATA, bus.FRAME_START, bus.HACT,
               bus.VACT, bus.LOCKED, bus.LOCK_LOST, bus.FRAME_SUM}, 0);
        px_q.delete();
        fsum      = '0;
        in_search = 1'b1;
        repeat (3) @(negedge DCLK);
        ARESETN = 1'b1;
        repeat (2) drive_line(16, 28, 1'b1, 0, 1'b0, -1);
        fv = '{16, 6, -1, 1'b0, 0, 0, 1'b0, 1'b0};
        drive_frame(fv, -1);
        fv = '{16, 0, -1, 1'b0, 16, 6, 1'b0, 1'b0};
        drive_frame(fv, -1);
        repeat (10) drive_cycle(1'b1, 1'b1, 1'b0, 24'h0);

        check("final_status_drained", st_q.size(), 0);
        check("final_pixels_drained", px_q.size(), 0);
        check("final_lost_pulses", lost_extra, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
